// File: rtl/pzcorebus_request_arbiter_ctrl.sv
// rtl/pzcorebus_request_arbiter_ctrl.sv - round-robin request arbiter with write-data owner FIFO
// Commands are granted round-robin and held until accepted; write data follows command order.
module pzcorebus_request_arbiter_ctrl #(
  parameter int REQUESTERS       = 2,
  parameter int COMMAND_WIDTH    = 64,
  parameter int WRITE_DATA_WIDTH = 128,
  parameter int OWNER_DEPTH      = 4,
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [REQUESTERS-1:0]                  i_mcmd_valid,
  output logic [REQUESTERS-1:0]                  o_scmd_accept,
  input  logic [REQUESTERS*COMMAND_WIDTH-1:0]    i_mcmd,
  input  logic [REQUESTERS-1:0]                  i_mcmd_write,
  input  logic [REQUESTERS-1:0]                  i_mdata_valid,
  input  logic [REQUESTERS-1:0]                  i_mdata_last,
  input  logic [REQUESTERS*WRITE_DATA_WIDTH-1:0] i_mdata,
  output logic [REQUESTERS-1:0]                  o_sdata_accept,
  output logic                                   o_mcmd_valid,
  input  logic                                   i_scmd_accept,
  output logic [COMMAND_WIDTH-1:0]               o_mcmd,
  output logic [IW-1:0]                          o_mcmd_id,
  output logic                                   o_mdata_valid,
  input  logic                                   i_sdata_accept,
  output logic [WRITE_DATA_WIDTH-1:0]            o_mdata,
  output logic                                   o_mdata_last
);

  localparam int PW   = $clog2(OWNER_DEPTH);
  localparam int CNTW = $clog2(OWNER_DEPTH + 1);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]     lock_id_q, lock_id_d;
  logic [IW-1:0]     owner_q [OWNER_DEPTH];
  logic [IW-1:0]     owner_d [OWNER_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic                  owner_full;
  logic                  owner_empty;
  logic [REQUESTERS-1:0] eligible;
  logic                  pick_found;
  logic [IW-1:0]         pick_id;
  logic [IW-1:0]         cand_id;
  int                    cand;
  logic                  cmd_valid;
  logic [IW-1:0]         granted_id;
  logic                  cmd_accept;
  logic                  push;
  logic                  pop;
  logic                  data_sel;
  logic [IW-1:0]         head_id;

  function automatic logic [IW-1:0] id_inc(input logic [IW-1:0] id);
    return (id == IW'(REQUESTERS - 1)) ? '0 : id + IW'(1);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OWNER_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Eligibility uses the registered full flag, so a same-cycle pop never frees a slot.
  assign owner_full  = (count_q == CNTW'(OWNER_DEPTH));
  assign owner_empty = (count_q == '0);
  assign eligible    = i_mcmd_valid & ~(i_mcmd_write & {REQUESTERS{owner_full}});

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = 0;
    cand_id    = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= REQUESTERS) cand = cand - REQUESTERS;
      cand_id = cand[IW-1:0];
      if (!pick_found && eligible[cand_id]) begin
        pick_found = 1'b1;
        pick_id    = cand_id;
      end
    end
  end

  always_comb begin
    granted_id = (state_q == ST_LOCKED) ? lock_id_q : pick_id;
    cmd_valid  = 1'b0;
    if (!i_rst) begin
      cmd_valid = (state_q == ST_LOCKED) ? i_mcmd_valid[lock_id_q] : pick_found;
    end
    cmd_accept = cmd_valid && i_scmd_accept;
    push       = cmd_accept && i_mcmd_write[granted_id];
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (cmd_valid) begin
      if (cmd_accept) begin
        state_d  = ST_IDLE;
        rr_ptr_d = id_inc(granted_id);
      end else if (state_q == ST_IDLE) begin
        state_d   = ST_LOCKED;
        lock_id_d = pick_id;
      end
    end
  end

  assign o_mcmd_valid  = cmd_valid;
  assign o_mcmd_id     = cmd_valid ? granted_id : '0;
  assign o_mcmd        = cmd_valid ? i_mcmd[granted_id*COMMAND_WIDTH +: COMMAND_WIDTH] : '0;
  assign o_scmd_accept = cmd_accept ? (REQUESTERS'(1) << granted_id) : '0;

  assign head_id        = owner_q[rd_ptr_q];
  assign data_sel       = !i_rst && !owner_empty;
  assign o_mdata_valid  = data_sel && i_mdata_valid[head_id];
  assign o_mdata_last   = data_sel && i_mdata_last[head_id];
  assign o_mdata        = data_sel ? i_mdata[head_id*WRITE_DATA_WIDTH +: WRITE_DATA_WIDTH] : '0;
  assign o_sdata_accept = (data_sel && i_sdata_accept) ? (REQUESTERS'(1) << head_id) : '0;
  assign pop            = o_mdata_valid && i_sdata_accept && o_mdata_last;

  always_comb begin
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      owner_d[wr_ptr_q] = granted_id;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop) count_d = count_q + CNTW'(1);
    else if (pop && !push) count_d = count_q - CNTW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < OWNER_DEPTH; i++) owner_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
    end
  end

endmodule

// File: doc/pzcorebus_request_arbiter_ctrl.md
Name: pzcorebus_request_arbiter_ctrl

Overview:
- Shares one pzcorebus request channel (command + write data) between REQUESTERS upstream masters.
- Round-robin command arbitration with a hold-until-accept grant.
- Write data is steered by an owner FIFO recorded at write-command accept, so data beats always follow command order.
- Sits in front of the request slicer feeding a shared memory-profile port; purely a sequencer and mux, with no payload storage.

Parameters:
- REQUESTERS, 2: number of upstream requesters; legal range is 2 to 16.
- COMMAND_WIDTH, 64: packed command width.
- WRITE_DATA_WIDTH, 128: packed write-data width, excluding the last flag.
- OWNER_DEPTH, 4: owner-FIFO entries, i.e. maximum write commands accepted whose data is not yet complete; legal range is 2 to 32.
- Derived: IW = max(1, clog2(REQUESTERS)).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_mcmd_valid  in  REQUESTERS  per-requester command valid
- o_scmd_accept  out  REQUESTERS  per-requester command accept
- i_mcmd  in  REQUESTERS*COMMAND_WIDTH  packed commands; requester k occupies slice k
- i_mcmd_write  in  REQUESTERS  command carries write data
- i_mdata_valid  in  REQUESTERS  per-requester write-data valid
- i_mdata_last  in  REQUESTERS  final beat of the burst
- i_mdata  in  REQUESTERS*WRITE_DATA_WIDTH  packed write data
- o_sdata_accept  out  REQUESTERS  per-requester data accept
- o_mcmd_valid  out  1  shared command valid
- i_scmd_accept  in  1  downstream command accept
- o_mcmd  out  COMMAND_WIDTH  selected command
- o_mcmd_id  out  IW  index of the granted requester
- o_mdata_valid  out  1  shared data valid
- i_sdata_accept  in  1  downstream data accept
- o_mdata  out  WRITE_DATA_WIDTH  selected data
- o_mdata_last  out  1  selected last flag

Behaviour:
Command arbiter, two states: IDLE and LOCKED.
- Eligible(k) = i_mcmd_valid[k] && !(i_mcmd_write[k] && owner_full).
- IDLE: combinationally pick the first eligible k scanning from rr_ptr upward with wrap. If one exists, o_mcmd_valid=1, o_mcmd=slice k, o_mcmd_id=k.
  - If i_scmd_accept=1 in that cycle: the command is accepted, state stays IDLE, rr_ptr <= k+1 (wrapping at REQUESTERS).
  - Otherwise: state <= LOCKED, lock_id <= k.
- LOCKED: the grant is fixed to lock_id regardless of other requesters or the full flag. Valid must not drop (protocol rule on requesters). On accept: IDLE, rr_ptr <= lock_id+1.
- o_scmd_accept[k] = i_scmd_accept && granted==k && o_mcmd_valid. All other bits are 0.
- No eligible requester: o_mcmd_valid=0, o_mcmd=0, o_mcmd_id=0.
- A write command presented while the owner FIFO is full is not granted in IDLE. Once LOCKED, fullness cannot change except by a pop, so an overflow is impossible.

Owner FIFO:
- Depth OWNER_DEPTH, IW bits wide.
- Push the granted id on command accept when i_mcmd_write[id]=1.
- Pop on data handshake (o_mdata_valid && i_sdata_accept && o_mdata_last).
- Simultaneous push and pop: both occur and the count is unchanged. The eligibility check uses the registered full flag only; a same-cycle pop does not free a slot.
- Wrap-around uses modulo-depth pointers.

Data steering:
- FIFO empty: o_mdata_valid=0, o_mdata=0, o_mdata_last=0, o_sdata_accept=0 for all requesters.
- FIFO non-empty with head h: o_mdata_valid=i_mdata_valid[h], o_mdata/o_mdata_last = slice h, o_sdata_accept[h]=i_sdata_accept. Other requesters are never accepted.
- Latency: zero-cycle combinational mux. The first data beat of a burst can be forwarded no earlier than the cycle after its command accept. Data presented by a requester earlier is held, not dropped.
- Non-last beats never pop the FIFO. Burst length is not checked.

Reset (i_rst=1 at a clock edge):
- State <= IDLE, rr_ptr <= 0, lock_id <= 0, FIFO emptied.
- While i_rst=1, all outputs are forced to 0: o_mcmd_valid, o_scmd_accept, o_mdata_valid, o_sdata_accept, o_mcmd, o_mcmd_id, o_mdata, o_mdata_last.
- Reset mid-burst discards outstanding ownership. Requesters must be reset together with this block.

Test Plan:
- Fairness: REQUESTERS=2, both present reads continuously, i_scmd_accept=1 -> ids alternate 0,1,0,1; rr_ptr resets to 0, so the first grant is id 0.
- Lock: requester 1 is granted while i_scmd_accept=0 for 3 cycles, then requester 0 raises valid -> o_mcmd_id stays 1 until accept; the next grant is id 0.
- Data ordering: write from 1 (2 beats) then write from 0 (1 beat), both sides' data valid -> beats from 1 are forwarded first; id 0's beat starts only after 1's last beat. o_sdata_accept[0]=0 until then.
- Full: OWNER_DEPTH=4, 4 writes accepted with data held off -> a 5th write is never granted, while a concurrent read from the other requester is granted. After one last beat pops, the 5th write is granted the following cycle.
- Simultaneous push/pop: FIFO count=1, a write accept coincides with a last-beat handshake -> count stays 1; the new head is the pushed id.
- Reset mid-operation: i_rst=1 for 1 cycle while LOCKED with 2 owner entries -> next cycle state is IDLE, FIFO is empty (o_mdata_valid=0), and the first grant after reset goes to the lowest valid id.
